// File: rtl/ed25519_pkg.sv
// ed25519_pkg: register map, ID constants, control/status bit positions and FSM state type
// shared by the Ed25519 signer front end and its engine.
package ed25519_pkg;
    localparam logic [7:0] ADDR_NAME0    = 8'h00;
    localparam logic [7:0] ADDR_NAME1    = 8'h01;
    localparam logic [7:0] ADDR_VERSION  = 8'h02;
    localparam logic [7:0] ADDR_CTRL     = 8'h08;
    localparam logic [7:0] ADDR_STATUS   = 8'h09;
    localparam logic [7:0] ADDR_SECRET0  = 8'h10;
    localparam logic [7:0] ADDR_SECRET7  = 8'h17;
    localparam logic [7:0] ADDR_PUBLIC0  = 8'h20;
    localparam logic [7:0] ADDR_PUBLIC7  = 8'h27;
    localparam logic [7:0] ADDR_MESSAGE0 = 8'h30;
    localparam logic [7:0] ADDR_MESSAGE7 = 8'h37;
    localparam logic [7:0] ADDR_R0       = 8'h40;
    localparam logic [7:0] ADDR_R7       = 8'h47;
    localparam logic [7:0] ADDR_S0       = 8'h50;
    localparam logic [7:0] ADDR_S7       = 8'h57;

    localparam logic [31:0] CORE_NAME0   = 32'h65643235;
    localparam logic [31:0] CORE_NAME1   = 32'h35313920;
    localparam logic [31:0] CORE_VERSION = 32'h31333337;

    localparam int CTRL_START_BIT   = 0;
    localparam int STATUS_READY_BIT = 0;
    localparam int STATUS_DONE_BIT  = 1;
    localparam int ENGINE_LATENCY   = 50;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    // Each 256-bit operand occupies an 8-word aligned block.
    function automatic logic in_block(input logic [7:0] addr, input logic [7:0] base);
        return addr[7:3] == base[7:3];
    endfunction
endpackage

// File: rtl/ed25519_sign_engine.sv
// ed25519_sign_engine: behavioural stand-in for the signing arithmetic; fixed latency,
// deterministic R/S derived from the operands so the front end can be exercised.
module ed25519_sign_engine
    import ed25519_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] secret,
    input  logic [255:0] public,
    input  logic [255:0] message,
    output logic         done_pulse,
    output logic [255:0] r,
    output logic [255:0] s
);
    logic [5:0]   cnt_q, cnt_d;
    logic [255:0] r_q, r_d, s_q, s_d, x;

    // s is kept below 2^252 so it is always reduced mod L.
    always_comb begin
        x     = public ^ message;
        cnt_d = start ? 6'(ENGINE_LATENCY) : (cnt_q != 6'd0 ? cnt_q - 6'd1 : cnt_q);
        r_d   = start ? secret + message : r_q;
        s_d   = start ? {4'b0, x[251:0] ^ {248'b0, x[255:252]}} : s_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            r_q   <= '0;
            s_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            r_q   <= r_d;
            s_q   <= s_d;
        end
    end

    assign done_pulse = cnt_q == 6'd1;
    assign r          = r_q;
    assign s          = s_q;
endmodule

// File: rtl/ed25519_sign_core.sv
// ed25519_sign_core: register-bus front end and start/done control for the Ed25519 signer.
module ed25519_sign_core
    import ed25519_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        error
);
    state_t            state_q, state_d;
    logic              start_q, start_d, done_q, done_d;
    logic [7:0][31:0]  secret_q, secret_d, public_q, public_d, message_q, message_d;
    logic [7:0][31:0]  r_q, r_d, s_q, s_d;
    logic [255:0]      eng_r, eng_s;
    logic              eng_done, busy, err, wr, go;
    logic [31:0]       rd;
    logic [2:0]        idx;

    assign busy = state_q == ST_BUSY;
    assign idx  = address[2:0];

    always_comb begin
        rd  = '0;
        err = 1'b0;
        if (address == ADDR_NAME0) begin
            rd  = CORE_NAME0;
            err = we;
        end else if (address == ADDR_NAME1) begin
            rd  = CORE_NAME1;
            err = we;
        end else if (address == ADDR_VERSION) begin
            rd  = CORE_VERSION;
            err = we;
        end else if (address == ADDR_CTRL) begin
            rd  = '0;
        end else if (address == ADDR_STATUS) begin
            rd[STATUS_READY_BIT] = !busy;
            rd[STATUS_DONE_BIT]  = done_q;
            err = we;
        end else if (in_block(address, ADDR_SECRET0)) begin
            rd  = secret_q[idx];
            err = we && busy;
        end else if (in_block(address, ADDR_PUBLIC0)) begin
            rd  = public_q[idx];
            err = we && busy;
        end else if (in_block(address, ADDR_MESSAGE0)) begin
            rd  = message_q[idx];
            err = we && busy;
        end else if (in_block(address, ADDR_R0)) begin
            rd  = r_q[idx];
            err = we;
        end else if (in_block(address, ADDR_S0)) begin
            rd  = s_q[idx];
            err = we;
        end else begin
            err = 1'b1;
        end
    end

    assign error     = cs && err;
    assign read_data = (cs && !err) ? rd : '0;
    assign wr        = cs && we && !err;
    assign go        = wr && address == ADDR_CTRL && write_data[CTRL_START_BIT] && !busy;

    always_comb begin
        secret_d  = secret_q;
        public_d  = public_q;
        message_d = message_q;
        if (wr && in_block(address, ADDR_SECRET0))  secret_d[idx]  = write_data;
        if (wr && in_block(address, ADDR_PUBLIC0))  public_d[idx]  = write_data;
        if (wr && in_block(address, ADDR_MESSAGE0)) message_d[idx] = write_data;
        state_d = state_q;
        start_d = 1'b0;
        done_d  = done_q;
        r_d     = r_q;
        s_d     = s_q;
        if (go) begin
            state_d = ST_BUSY;
            start_d = 1'b1;
            done_d  = 1'b0;
        end else if (busy && eng_done) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            r_d     = eng_r;
            s_d     = eng_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            secret_q  <= '0;
            public_q  <= '0;
            message_q <= '0;
            r_q       <= '0;
            s_q       <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            done_q    <= done_d;
            secret_q  <= secret_d;
            public_q  <= public_d;
            message_q <= message_d;
            r_q       <= r_d;
            s_q       <= s_d;
        end
    end

    ed25519_sign_engine u_engine (
        .clk        (clk),
        .rst        (rst),
        .start      (start_q),
        .secret     (secret_q),
        .public     (public_q),
        .message    (message_q),
        .done_pulse (eng_done),
        .r          (eng_r),
        .s          (eng_s)
    );
endmodule

// File: tb/tb_ed25519_sign_core.sv
// tb_ed25519_sign_core: table-driven register checks, directed start/busy/reset sequences
// and randomized signing runs against a reference model of the engine stub.
module tb_ed25519_sign_core;
    logic        clk = 1'b0, rst = 1'b0, cs = 1'b0, we = 1'b0;
    logic [7:0]  address = 8'h00;
    logic [31:0] write_data = 32'h0, read_data;
    logic        error;
    int          checks = 0, errors = 0, n_done = 0;

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        e;
    } vec_t;

    always #5 clk = ~clk;

    ed25519_sign_core dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .we         (we),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .error      (error)
    );

    always @(posedge clk) if (dut.eng_done) n_done <= n_done + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic acc(input logic w, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e);
        @(negedge clk);
        cs = 1'b1; we = w; address = a; write_data = d;
        #1;
        rd = read_data;
        e  = error;
        @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic e;
        acc(1'b1, a, d, rd, e);
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic e;
        acc(1'b0, a, 32'h0, rd, e);
        chk(nm, rd, exp);
    endtask

    task automatic poll(input int b, input string nm);
        logic [31:0] v;
        logic e;
        int n;
        for (n = 0; n < 500; n++) begin
            acc(1'b0, 8'h09, 32'h0, v, e);
            if (v[b]) break;
        end
        chk({nm, " poll"}, 32'(n < 500), 32'd1);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] model_r(input logic [255:0] sec, input logic [255:0] msg);
        return sec + msg;
    endfunction

    function automatic logic [255:0] model_s(input logic [255:0] pub, input logic [255:0] msg);
        logic [255:0] x;
        x = pub ^ msg;
        return (x % (256'd1 << 252)) ^ (x >> 252);
    endfunction

    task automatic load(input logic [255:0] sec, input logic [255:0] pub, input logic [255:0] msg);
        for (int i = 0; i < 8; i++) begin
            wr(8'h10 + 8'(i), sec[32*i +: 32]);
            wr(8'h20 + 8'(i), pub[32*i +: 32]);
            wr(8'h30 + 8'(i), msg[32*i +: 32]);
        end
    endtask

    task automatic check_rs(input logic [255:0] er, input logic [255:0] es);
        for (int i = 0; i < 8; i++) begin
            rd_chk($sformatf("R%0d", i), 8'h40 + 8'(i), er[32*i +: 32]);
            rd_chk($sformatf("S%0d", i), 8'h50 + 8'(i), es[32*i +: 32]);
        end
    endtask

    vec_t tbl[18];

    initial begin
        logic [255:0] sec, pub, msg;
        logic [31:0]  rd;
        logic         e;
        int           nd0;
        tbl[0]  = '{1'b0, 8'h00, 32'h0,        32'h65643235, 1'b0};
        tbl[1]  = '{1'b0, 8'h01, 32'h0,        32'h35313920, 1'b0};
        tbl[2]  = '{1'b0, 8'h02, 32'h0,        32'h31333337, 1'b0};
        tbl[3]  = '{1'b0, 8'h09, 32'h0,        32'h00000001, 1'b0};
        tbl[4]  = '{1'b1, 8'h40, 32'hDEADBEEF, 32'h0,        1'b1};
        tbl[5]  = '{1'b1, 8'h02, 32'hDEADBEEF, 32'h0,        1'b1};
        tbl[6]  = '{1'b1, 8'hFF, 32'hDEADBEEF, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 8'h40, 32'h0,        32'h0,        1'b0};
        tbl[8]  = '{1'b0, 8'h02, 32'h0,        32'h31333337, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 32'h0,        32'h65643235, 1'b0};
        tbl[10] = '{1'b0, 8'hFF, 32'h0,        32'h0,        1'b1};
        tbl[11] = '{1'b0, 8'h08, 32'h0,        32'h0,        1'b0};
        tbl[12] = '{1'b1, 8'h09, 32'h3,        32'h0,        1'b1};
        tbl[13] = '{1'b0, 8'h18, 32'h0,        32'h0,        1'b1};
        tbl[14] = '{1'b0, 8'h0A, 32'h0,        32'h0,        1'b1};
        tbl[15] = '{1'b1, 8'h58, 32'h1,        32'h0,        1'b1};
        tbl[16] = '{1'b0, 8'h57, 32'h0,        32'h0,        1'b0};
        tbl[17] = '{1'b1, 8'h01, 32'h1,        32'h0,        1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            acc(tbl[i].w, tbl[i].a, tbl[i].d, rd, e);
            chk($sformatf("tbl%0d rd", i), rd, tbl[i].rd);
            chk($sformatf("tbl%0d err", i), 32'(e), 32'(tbl[i].e));
        end

        acc(1'b1, 8'h08, 32'h0, rd, e);
        chk("ctrl0 err", 32'(e), 32'd0);
        rd_chk("ctrl0 status", 8'h09, 32'h1);

        for (int i = 0; i < 8; i++) wr(8'h10 + 8'(i), 32'(i));
        for (int i = 0; i < 8; i++) rd_chk($sformatf("SECRET%0d", i), 8'h10 + 8'(i), 32'(i));
        sec = '0;
        for (int i = 0; i < 8; i++) sec[32*i +: 32] = 32'(i);
        nd0 = n_done;
        wr(8'h08, 32'h1);
        rd_chk("busy status", 8'h09, 32'h0);
        acc(1'b1, 8'h30, 32'h1234, rd, e);
        chk("busy msg write err", 32'(e), 32'd1);
        rd_chk("busy msg unchanged", 8'h30, 32'h0);
        acc(1'b1, 8'h08, 32'h1, rd, e);
        chk("busy ctrl err", 32'(e), 32'd0);
        poll(1, "first done");
        rd_chk("done status", 8'h09, 32'h3);
        check_rs(model_r(sec, '0), model_s('0, '0));
        repeat (70) @(posedge clk);
        chk("single completion", 32'(n_done - nd0), 32'd1);
        rd_chk("status after idle", 8'h09, 32'h3);

        for (int v = 0; v < 100; v++) begin
            sec = rand256();
            pub = rand256();
            msg = rand256();
            poll(0, "ready");
            load(sec, pub, msg);
            wr(8'h08, 32'h1);
            poll(1, "done");
            check_rs(model_r(sec, msg), model_s(pub, msg));
        end

        load(rand256(), rand256(), rand256());
        wr(8'h08, 32'h1);
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #13 rst = 1'b1;
        rd_chk("reset status", 8'h09, 32'h1);
        check_rs('0, '0);
        for (int i = 0; i < 8; i++) begin
            rd_chk($sformatf("rst SECRET%0d", i), 8'h10 + 8'(i), 32'h0);
            rd_chk($sformatf("rst PUBLIC%0d", i), 8'h20 + 8'(i), 32'h0);
            rd_chk($sformatf("rst MESSAGE%0d", i), 8'h30 + 8'(i), 32'h0);
        end
        repeat (60) @(posedge clk);
        rd_chk("no late done", 8'h09, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
